// File: rtl/shift_pipe_if.sv
// shift_pipe_if: request/result handshake bundle for shift_pipe.
// The slave modport is the shifter's view; master is the producer/consumer view.
interface shift_pipe_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int TAG_W   = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   data_operandA;
   logic [SHAMT_W-1:0] ctrl_shiftamt;
   logic [1:0]         ctrl_op;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   data_result;
   logic [TAG_W-1:0]   out_tag;
   logic               out_err;

   modport slave (
      input  in_valid, data_operandA, ctrl_shiftamt, ctrl_op, in_tag, out_ready,
      output in_ready, out_valid, data_result, out_tag, out_err
   );

   modport master (
      output in_valid, data_operandA, ctrl_shiftamt, ctrl_op, in_tag, out_ready,
      input  in_ready, out_valid, data_result, out_tag, out_err
   );
endinterface

// File: rtl/shift_pipe.sv
// shift_pipe: SHAMT_W-stage logarithmic shifter pipeline (SLL/SRL/SRA/ROR) with a global stall.
// Optional ROR datapath compiled in by defining SHIFT_PIPE_ROTATE_EN; otherwise op 11 passes through with out_err set.
module shift_pipe #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int TAG_W   = 4
) (
   input  logic        clock,
   input  logic        reset,
   shift_pipe_if.slave bus
);
   localparam int NS = SHAMT_W;
   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   typedef struct packed {
      logic               valid;
      logic [1:0]         op;
      logic [SHAMT_W-1:0] shamt;
      logic               sign;
      logic               err;
      logic [TAG_W-1:0]   tag;
      logic [WIDTH-1:0]   data;
   } stage_t;

   // Single conditional shift step of a fixed distance; sign is the operand MSB captured at input.
   function automatic logic [WIDTH-1:0] shift_step(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       op,
      input logic             sign,
      input int unsigned      amt
   );
      logic [WIDTH-1:0] ones;
      logic [WIDTH-1:0] r;
      ones = '1;
      case (op)
         OP_SLL:  r = d << amt;
         OP_SRL:  r = d >> amt;
         OP_SRA:  r = (d >> amt) | (sign ? ~(ones >> amt) : {WIDTH{1'b0}});
`ifdef SHIFT_PIPE_ROTATE_EN
         OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
`else
         OP_ROR:  r = d;
`endif
         default: r = d;
      endcase
      return r;
   endfunction

   logic             advance_s;
   stage_t           in_s;
   stage_t           last_s;
   stage_t           stage_d [NS-1];
   stage_t           stage_q [NS-1];
   logic             out_valid_d, out_valid_q;
   logic [WIDTH-1:0] out_data_d,  out_data_q;
   logic [TAG_W-1:0] out_tag_d,   out_tag_q;
   logic             out_err_d,   out_err_q;

   // The only stall source is a held result at the output.
   assign advance_s        = !(out_valid_q && !bus.out_ready);
   assign bus.in_ready     = advance_s;
   assign bus.out_valid    = out_valid_q;
   assign bus.data_result  = out_data_q;
   assign bus.out_tag      = out_tag_q;
   assign bus.out_err      = out_err_q;

   // Capture the request; an absent request enters as an all-zero bubble.
   always_comb begin
      in_s = '0;
      if (bus.in_valid) begin
         in_s.valid = 1'b1;
         in_s.op    = bus.ctrl_op;
         in_s.shamt = bus.ctrl_shiftamt;
         in_s.sign  = bus.data_operandA[WIDTH-1];
         in_s.tag   = bus.in_tag;
         in_s.data  = bus.data_operandA;
`ifdef SHIFT_PIPE_ROTATE_EN
         in_s.err   = 1'b0;
`else
         in_s.err   = (bus.ctrl_op == OP_ROR);
`endif
      end else begin
         in_s = '0;
      end
   end

   // Stage k shifts by 2^k when shamt bit k is set; the final stage feeds the output registers.
   always_comb begin
      stage_d[0] = in_s;
      if (in_s.shamt[0]) begin
         stage_d[0].data = shift_step(in_s.data, in_s.op, in_s.sign, 32'd1);
      end else begin
         stage_d[0].data = in_s.data;
      end
      for (int k = 1; k < NS-1; k++) begin
         stage_d[k] = stage_q[k-1];
         if (stage_q[k-1].shamt[k]) begin
            stage_d[k].data = shift_step(stage_q[k-1].data, stage_q[k-1].op,
                                         stage_q[k-1].sign, 32'd1 << k);
         end else begin
            stage_d[k].data = stage_q[k-1].data;
         end
      end
      last_s      = stage_q[NS-2];
      out_valid_d = last_s.valid;
      out_tag_d   = last_s.tag;
      out_err_d   = last_s.err;
      if (last_s.shamt[NS-1]) begin
         out_data_d = shift_step(last_s.data, last_s.op, last_s.sign, 32'd1 << (NS-1));
      end else begin
         out_data_d = last_s.data;
      end
   end

   // Pipeline registers: synchronous clear, otherwise advance in lockstep or hold as a whole.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < NS-1; k++) begin
            stage_q[k] <= '0;
         end
         out_valid_q <= 1'b0;
         out_data_q  <= {WIDTH{1'b0}};
         out_tag_q   <= {TAG_W{1'b0}};
         out_err_q   <= 1'b0;
      end else if (advance_s) begin
         stage_q     <= stage_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_tag_q   <= out_tag_d;
         out_err_q   <= out_err_d;
      end
   end
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed, burst/stall, reset and random checks of shift_pipe against a queue-based model.
module tb_shift_pipe;
   localparam int W  = 32;
   localparam int SW = 5;
   localparam int TW = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   shift_pipe_if #(.WIDTH(W), .SHAMT_W(SW), .TAG_W(TW)) bus ();
   shift_pipe_if #(.WIDTH(8), .SHAMT_W(3),  .TAG_W(TW)) bus8 ();

   shift_pipe #(.WIDTH(W), .SHAMT_W(SW), .TAG_W(TW)) dut (
      .clock(clock), .reset(reset), .bus(bus)
   );
   shift_pipe #(.WIDTH(8), .SHAMT_W(3), .TAG_W(TW)) dut8 (
      .clock(clock), .reset(reset), .bus(bus8)
   );

   typedef struct {
      logic [W-1:0]  data;
      logic [TW-1:0] tag;
      logic          err;
      int            acc_cyc;
      int            acc_stall;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   stall_cnt = 0;
   logic after_reset = 1'b0;
   logic prev_hold = 1'b0;
   logic [W-1:0]  prev_data;
   logic [TW-1:0] prev_tag;
   logic          prev_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference behaviour straight from the operation definitions.
   function automatic logic [W-1:0] model(input logic [W-1:0] a, input int s,
                                          input logic [1:0] op, output logic err);
      logic [W-1:0] r;
      err = 1'b0;
      case (op)
         2'b00:   r = a << s;
         2'b01:   r = a >> s;
         2'b10:   r = W'($signed(a) >>> s);
         default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
            r = (a >> s) | (a << (W - s));
`else
            r   = a;
            err = 1'b1;
`endif
         end
      endcase
      return r;
   endfunction

   // Compare process: sampled mid low phase, well away from the rising edge.
   always @(negedge clock) begin
      #2;
      cyc++;
      if (reset) begin
         exp_q.delete();
         prev_hold   = 1'b0;
         after_reset = 1'b1;
      end else begin
         if (after_reset) begin
            check("post_reset_out_valid", bus.out_valid, 0);
            check("post_reset_in_ready", bus.in_ready, 1);
            check("post_reset_data", bus.data_result, 0);
            check("post_reset_tag", bus.out_tag, 0);
            check("post_reset_err", bus.out_err, 0);
            after_reset = 1'b0;
         end
         check("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
         if (bus.out_valid) begin
            if (prev_hold) begin
               check("stall_stable_data", bus.data_result, prev_data);
               check("stall_stable_tag", bus.out_tag, prev_tag);
               check("stall_stable_err", bus.out_err, prev_err);
            end else if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL stale_output: out_valid with data 0x%0h tag %0d, expected no result (cycle %0d)",
                        bus.data_result, bus.out_tag, cyc);
            end else begin
               check("result_data", bus.data_result, exp_q[0].data);
               check("result_tag", bus.out_tag, exp_q[0].tag);
               check("result_err", bus.out_err, exp_q[0].err);
               check("latency", cyc - exp_q[0].acc_cyc, 5 + stall_cnt - exp_q[0].acc_stall);
            end
            if (bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_data = bus.data_result;
         prev_tag  = bus.out_tag;
         prev_err  = bus.out_err;
         if (!bus.in_ready) stall_cnt++;
         if (bus.in_valid && bus.in_ready) begin
            exp_t e;
            e.data      = model(bus.data_operandA, int'(bus.ctrl_shiftamt), bus.ctrl_op, e.err);
            e.tag       = bus.in_tag;
            e.acc_cyc   = cyc;
            e.acc_stall = stall_cnt;
            exp_q.push_back(e);
         end
      end
   end

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [SW-1:0] s,
                        input logic [1:0] op, input logic [TW-1:0] tag, input logic ordy);
      @(negedge clock);
      bus.in_valid      = v;
      bus.data_operandA = a;
      bus.ctrl_shiftamt = s;
      bus.ctrl_op       = op;
      bus.in_tag        = tag;
      bus.out_ready     = ordy;
   endtask

   // Directed request whose expected result is hand-computed; pins the model too.
   task automatic directed(input string name, input logic [W-1:0] a, input logic [SW-1:0] s,
                           input logic [1:0] op, input logic [TW-1:0] tag,
                           input logic [W-1:0] lit, input logic lit_err);
      logic merr;
      logic [W-1:0] m;
      m = model(a, int'(s), op, merr);
      check({name, "_model"}, {merr, m}, {lit_err, lit});
      drive(1'b1, a, s, op, tag, 1'b1);
      #3;
      check({name, "_accept"}, bus.in_ready, 1);
   endtask

   task automatic drain();
      int c;
      drive(1'b0, '0, '0, 2'b00, '0, 1'b1);
      c = 0;
      while (exp_q.size() != 0 && c < 60) begin
         @(negedge clock);
         c++;
      end
      #3;
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      int idx;
      int s0;
      int found;
      bus.in_valid = 1'b0; bus.data_operandA = '0; bus.ctrl_shiftamt = '0;
      bus.ctrl_op = 2'b00; bus.in_tag = '0; bus.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.data_operandA = '0; bus8.ctrl_shiftamt = '0;
      bus8.ctrl_op = 2'b00; bus8.in_tag = '0; bus8.out_ready = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      directed("sra_neg", 32'h8000_0010, 5'd4,  2'b10, 4'h5, 32'hF800_0001, 1'b0);
      directed("srl",     32'h8000_0010, 5'd4,  2'b01, 4'h6, 32'h0800_0001, 1'b0);
      directed("sll_31",  32'h0000_000F, 5'd31, 2'b00, 4'h7, 32'h8000_0000, 1'b0);
      directed("sra_pos", 32'h7FFF_FFFF, 5'd31, 2'b10, 4'h8, 32'h0000_0000, 1'b0);
      directed("sra_0",   32'h8765_4321, 5'd0,  2'b10, 4'h9, 32'h8765_4321, 1'b0);
`ifdef SHIFT_PIPE_ROTATE_EN
      directed("ror_1",   32'h0000_0001, 5'd1,  2'b11, 4'hA, 32'h8000_0000, 1'b0);
`else
      directed("ror_1",   32'h0000_0001, 5'd1,  2'b11, 4'hA, 32'h0000_0001, 1'b1);
`endif
      drain();

      // Eight back-to-back requests; consumer stalls from relative cycle 3 for 4 cycles.
      idx = 0;
      s0  = stall_cnt;
      for (int c = 0; c < 40 && idx < 8; c++) begin
         drive(1'b1, 32'h1234_5678 + 32'(idx), 5'(idx * 3), 2'(idx), 4'(idx),
               !(c >= 3 && c < 7));
         #3;
         if (bus.in_ready) idx++;
      end
      check("burst_all_accepted", idx, 8);
      check("burst_stall_cycles", stall_cnt - s0, 2);
      drain();

      // Reset with three operations in flight; nothing may emerge afterwards.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'hA5A5_0000 | 32'(i), 5'd2, 2'b01, 4'(12 + i), 1'b1);
      end
      drive(1'b0, '0, '0, 2'b00, '0, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (12) @(negedge clock);
      #3;
      check("reset_flush_out_valid", bus.out_valid, 0);

      // Random traffic with random back-pressure.
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 9) < 7), $urandom, 5'($urandom_range(0, 31)),
               2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) != 0));
      end
      drain();

      // Narrow instance: SRA of 0x90 by 7 after exactly 3 cycles.
      @(negedge clock);
      bus8.in_valid = 1'b1; bus8.data_operandA = 8'h90; bus8.ctrl_shiftamt = 3'd7;
      bus8.ctrl_op = 2'b10; bus8.in_tag = 4'hC;
      #3;
      check("w8_accept", bus8.in_ready, 1);
      found = -1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         bus8.in_valid = 1'b0;
         #2;
         if (bus8.out_valid) begin
            found = c;
            break;
         end
      end
      check("w8_latency", found, 3);
      check("w8_data", bus8.data_result, 8'hFF);
      check("w8_tag", bus8.out_tag, 4'hC);
      check("w8_err", bus8.out_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
